hack_mem_ctrl: RTL

Parametrised memory subsystem for the Hack system. It holds the instruction ROM and data RAM and owns the boot/run mode state machine that hands memory from the shell loader to the CPU. It decodes a memory-mapped I/O window onto a valid/ack side port. It sits between the shell bus, the CPU core and the peripherals (LCD, UART), and succeeds the fixed-size single-ROM top-level arrangement.

---
 rtl/hack_pkg.sv | 29 ++
 rtl/hack_sp_ram.sv | 27 ++
 rtl/hack_mem_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared encodings and constants for the Hack memory subsystem.
package hack_pkg;

   typedef enum logic {
      MODE_BOOT = 1'b0,
      MODE_RUN  = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IO_IDLE = 2'd0,
      IO_REQ  = 2'd1,
      IO_DONE = 2'd2
   } io_state_e;

   localparam int unsigned IO_BASE_DEFAULT = 32'h4000;
   localparam int unsigned IO_WIN          = 16;

   localparam logic [3:0] IO_LCD     = 4'd0;
   localparam logic [3:0] IO_UART_RX = 4'd1;
   localparam logic [3:0] IO_UART_TX = 4'd2;

   // Unsigned wrap makes addresses below base land far outside the window.
   function automatic logic in_window(input logic [31:0] addr,
                                      input int unsigned base,
                                      input int unsigned size);
      return (addr - 32'(base)) < 32'(size);
   endfunction

endpackage

// File: rtl/hack_sp_ram.sv
// Single-port block RAM with one-cycle registered read; contents are never cleared.
module hack_sp_ram #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Only the read register is reset; the array keeps its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[addr];
   end

endmodule

// File: rtl/hack_mem_ctrl.sv
// Hack memory subsystem: ROM/RAM, boot/run hand-over FSM and I/O valid/ack port.
// Define HACK_MEM_CHECKSUM_EN to add o_checksum (sum of shell ROM write data).
module hack_mem_ctrl
   import hack_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned ROM_DEPTH = 1024,
   parameter int unsigned RAM_DEPTH = 1024,
   parameter int unsigned IO_BASE   = IO_BASE_DEFAULT
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              i_shell_cs,
   input  logic              i_shell_sel,
   input  logic              i_shell_write,
   input  logic [ADDR_W-1:0] i_shell_addr,
   input  logic [DATA_W-1:0] i_shell_wdata,
   output logic [DATA_W-1:0] o_shell_rdata,
   output logic              o_shell_rvalid,
   input  logic              i_run,
   input  logic              i_boot,
   output logic              o_mode,
   output logic              o_cpu_reset,
   input  logic [ADDR_W-1:0] i_cpu_pc,
   output logic [DATA_W-1:0] o_cpu_inst,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic              i_cpu_write,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_stall,
   output logic              o_io_req,
   output logic              o_io_write,
   output logic [3:0]        o_io_addr,
   output logic [DATA_W-1:0] o_io_wdata,
   input  logic              i_io_ack,
   input  logic [DATA_W-1:0] i_io_rdata
`ifdef HACK_MEM_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] o_checksum
`endif
);

   localparam int unsigned ROM_AW = $clog2(ROM_DEPTH);
   localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

   mode_e             mode_q;
   io_state_e         io_state_q;
   logic              run;
   logic              shell_acc;
   logic              shell_rom_in;
   logic              shell_ram_in;
   logic              pc_in;
   logic              cpu_ram_hit;
   logic              cpu_io_hit;
   logic              abort;
   logic              io_start;
   logic              rom_we;
   logic              ram_we;
   logic [ROM_AW-1:0] rom_addr;
   logic [RAM_AW-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] rom_rdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [3:0]        io_off;

   logic              cpu_reset_q;
   logic              shell_rvalid_q;
   logic              shell_sel_q;
   logic              shell_in_q;
   logic              fetch_ok_q;
   logic              cpu_ram_rd_q;
   logic              io_req_q;
   logic              io_write_q;
   logic [3:0]        io_addr_q;
   logic [DATA_W-1:0] io_wdata_q;
   logic [DATA_W-1:0] io_rdata_q;

   // Address decode for both masters.
   assign run          = (mode_q == MODE_RUN);
   assign shell_acc    = !run && i_shell_cs;
   assign shell_rom_in = in_window(32'(i_shell_addr), 0, ROM_DEPTH);
   assign shell_ram_in = in_window(32'(i_shell_addr), 0, RAM_DEPTH);
   assign pc_in        = in_window(32'(i_cpu_pc), 0, ROM_DEPTH);
   assign cpu_ram_hit  = in_window(32'(i_cpu_addr), 0, RAM_DEPTH);
   assign cpu_io_hit   = in_window(32'(i_cpu_addr), IO_BASE, IO_WIN);
   assign io_off       = 4'(i_cpu_addr - ADDR_W'(IO_BASE));

   assign abort    = run && i_boot;
   assign io_start = run && !i_boot && (io_state_q == IO_IDLE) && cpu_io_hit;

   // Memory ports belong to the shell in BOOT and to the CPU in RUN.
   assign rom_we    = shell_acc && i_shell_write && !i_shell_sel && shell_rom_in;
   assign ram_we    = run ? (i_cpu_write && cpu_ram_hit)
                          : (shell_acc && i_shell_write && i_shell_sel && shell_ram_in);
   assign rom_addr  = run ? ROM_AW'(i_cpu_pc) : ROM_AW'(i_shell_addr);
   assign ram_addr  = run ? RAM_AW'(i_cpu_addr) : RAM_AW'(i_shell_addr);
   assign ram_wdata = run ? i_cpu_wdata : i_shell_wdata;

   hack_sp_ram #(.DEPTH(ROM_DEPTH), .WIDTH(DATA_W)) u_rom (
      .clk   (CLK),
      .rst_n (RST_N),
      .we    (rom_we),
      .addr  (rom_addr),
      .wdata (i_shell_wdata),
      .rdata (rom_rdata)
   );

   hack_sp_ram #(.DEPTH(RAM_DEPTH), .WIDTH(DATA_W)) u_ram (
      .clk   (CLK),
      .rst_n (RST_N),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Mode FSM, I/O FSM and the read-path qualifiers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_q         <= MODE_BOOT;
         cpu_reset_q    <= 1'b1;
         shell_rvalid_q <= 1'b0;
         shell_sel_q    <= 1'b0;
         shell_in_q     <= 1'b0;
         fetch_ok_q     <= 1'b0;
         cpu_ram_rd_q   <= 1'b0;
         io_state_q     <= IO_IDLE;
         io_req_q       <= 1'b0;
         io_write_q     <= 1'b0;
         io_addr_q      <= '0;
         io_wdata_q     <= '0;
         io_rdata_q     <= '0;
      end else begin
         if (run) begin
            if (i_boot) mode_q <= MODE_BOOT;
         end else if (i_run && !i_boot) begin
            mode_q <= MODE_RUN;
         end
         // Released only once RUN has already lasted one full cycle.
         cpu_reset_q    <= !(run && !i_boot);
         shell_rvalid_q <= shell_acc && !i_shell_write;
         shell_sel_q    <= i_shell_sel;
         shell_in_q     <= i_shell_sel ? shell_ram_in : shell_rom_in;
         fetch_ok_q     <= run && pc_in;
         cpu_ram_rd_q   <= run && cpu_ram_hit;

         if (abort) begin
            io_state_q <= IO_IDLE;
            io_req_q   <= 1'b0;
         end else begin
            case (io_state_q)
               IO_IDLE: begin
                  if (io_start) begin
                     io_state_q <= IO_REQ;
                     io_req_q   <= 1'b1;
                     io_write_q <= i_cpu_write;
                     io_addr_q  <= io_off;
                     io_wdata_q <= i_cpu_wdata;
                  end
               end
               IO_REQ: begin
                  if (i_io_ack) begin
                     io_state_q <= IO_DONE;
                     io_req_q   <= 1'b0;
                     io_rdata_q <= io_write_q ? '0 : i_io_rdata;
                  end
               end
               default: io_state_q <= IO_IDLE;
            endcase
         end
      end
   end

`ifdef HACK_MEM_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)      checksum_q <= '0;
      else if (abort)  checksum_q <= '0;
      else if (rom_we) checksum_q <= checksum_q + i_shell_wdata;
   end

   assign o_checksum = checksum_q;
`endif

   assign o_mode         = run;
   assign o_cpu_reset    = cpu_reset_q;
   assign o_shell_rvalid = shell_rvalid_q;
   assign o_shell_rdata  = (shell_rvalid_q && shell_in_q) ? (shell_sel_q ? ram_rdata : rom_rdata) : '0;
   assign o_cpu_inst     = fetch_ok_q ? rom_rdata : '0;
   assign o_cpu_rdata    = (io_state_q == IO_DONE) ? io_rdata_q : (cpu_ram_rd_q ? ram_rdata : '0);
   assign o_cpu_stall    = io_start || (io_state_q == IO_REQ);
   assign o_io_req       = io_req_q;
   assign o_io_write     = io_write_q;
   assign o_io_addr      = io_addr_q;
   assign o_io_wdata     = io_wdata_q;

endmodule
